// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0  initial release
// ============================================================================
package if_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

  // addi x0,x0,0 -- what decode sees whenever IF/ID carries no instruction
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_INCR   = 4;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Purpose  : Single-outstanding instruction-memory request/response bundle.
//            master = fetch stage, slave = instruction memory.
// Revision : 1.0  initial release
// ============================================================================
interface if_stage_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register. Load writes a valid instruction with its
//            pc and link address; flush writes a NOP bubble; otherwise hold.
// Revision : 1.0  initial release
// ============================================================================
module ifid_reg
  import if_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_plus4;
  logic               r_valid;

  // Flush wins over load; a bubble keeps the last pc so only instr/valid change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_pc       <= '0;
      r_pc_plus4 <= PC_W'(PC_INCR);
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc + PC_W'(PC_INCR);
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch: PC, fetch FSM (FETCH/DRAIN/HOLD), skid buffer
//            and the IF/ID register. Honours hazard stalls and decode redirects.
// Options  : IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
// Revision : 1.0  initial release
// ============================================================================
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write_zero,
  input  logic               IFID_pipeline_write_zero,
  input  logic               redirect,
  input  logic [PC_W-1:0]    dest_pc,
  if_stage_if.master         imem,
  output logic [INSTR_W-1:0] instr_D,
  output logic [PC_W-1:0]    pc_D,
  output logic [PC_W-1:0]    pc_plus4_D,
  output logic               valid_D
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  if_state_e          r_state;
  if_state_e          w_state_nxt;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    r_drain_addr;
  logic [INSTR_W-1:0] r_skid;
  logic               r_active;

  logic               w_stall;
  logic               w_redir;
  logic [PC_W-1:0]    w_dest;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_load;
  logic               w_flush;
  logic               w_skid_ld;
  logic               w_drain_ld;
  logic [INSTR_W-1:0] w_load_instr;

  assign w_stall  = pc_write_zero | IFID_pipeline_write_zero;
  assign w_redir  = redirect & ~w_stall;
  assign w_dest   = dest_pc & ~(PC_W'(3));
  assign w_pc_inc = r_fetch_pc + PC_W'(PC_INCR);

  // r_active keeps imem_req low through reset and for the first cycle after it
  assign imem.imem_req  = r_active & (r_state != HOLD);
  assign imem.imem_addr = (r_state == DRAIN) ? r_drain_addr : r_fetch_pc;

  // Next-state, PC update and IF/ID control; an accepted redirect beats everything
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_fetch_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_skid_ld    = 1'b0;
    w_drain_ld   = 1'b0;
    w_load_instr = imem.imem_rdata;
    if (!r_active) begin
      // No request issued yet, so a redirect only retargets the first fetch
      if (w_redir) begin
        w_flush  = 1'b1;
        w_pc_nxt = w_dest;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_redir) begin
            w_flush  = 1'b1;
            w_pc_nxt = w_dest;
            if (!imem.imem_rvalid) begin
              // Outstanding request must still complete; remember its address
              w_state_nxt = DRAIN;
              w_drain_ld  = 1'b1;
            end
          end else if (imem.imem_rvalid) begin
            if (!w_stall) begin
              w_load   = 1'b1;
              w_pc_nxt = w_pc_inc;
            end else begin
              w_skid_ld   = 1'b1;
              w_state_nxt = HOLD;
            end
          end else if (!w_stall) begin
            w_flush = 1'b1;
          end
        end
        HOLD: begin
          if (w_redir) begin
            w_flush     = 1'b1;
            w_pc_nxt    = w_dest;
            w_state_nxt = FETCH;
          end else if (!w_stall) begin
            w_load       = 1'b1;
            w_load_instr = r_skid;
            w_pc_nxt     = w_pc_inc;
            w_state_nxt  = FETCH;
          end
        end
        DRAIN: begin
          // Stale response is thrown away; a redirect here only moves the target
          if (w_redir) w_pc_nxt = w_dest;
          if (!w_stall) w_flush = 1'b1;
          if (imem.imem_rvalid) w_state_nxt = FETCH;
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // FSM state, fetch PC, drain address and skid buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= FETCH;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= '0;
      r_skid       <= INSTR_W'(NOP_INSTR);
      r_active     <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      if (w_drain_ld) r_drain_addr <= r_fetch_pc;
      if (w_skid_ld)  r_skid       <= imem.imem_rdata;
    end
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (w_load_instr),
    .i_pc       (r_fetch_pc),
    .o_instr    (instr_D),
    .o_pc       (pc_D),
    .o_pc_plus4 (pc_plus4_D),
    .o_valid    (valid_D)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Count valid IF/ID writes and stalled cycles, wrapping at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_load)  r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Randomized self-checking bench for if_stage. Random memory
//            latency, stalls and redirects; delivered instructions are checked
//            against the expected program-order PC stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;
  import if_pkg::*;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;
  localparam logic [15:0] RST_PC  = 16'hFFF8;

  typedef struct {
    int          e;
    logic [15:0] tgt;
  } redir_t;

  logic        clk;
  logic        reset;
  logic        pcw0;
  logic        ifidw0;
  logic        redirect;
  logic [15:0] dest_pc;
  logic [31:0] instr_D;
  logic [15:0] pc_D;
  logic [15:0] pc_plus4_D;
  logic        valid_D;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

  if_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .pc_write_zero            (pcw0),
    .IFID_pipeline_write_zero (ifidw0),
    .redirect                 (redirect),
    .dest_pc                  (dest_pc),
    .imem                     (imem),
    .instr_D                  (instr_D),
    .pc_D                     (pc_D),
    .pc_plus4_D               (pc_plus4_D),
    .valid_D                  (valid_D)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt           (perf_fetch_cnt),
    .perf_stall_cnt           (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          deliveries = 0;
  int          exp_stall = 0;
  redir_t      rq[$];
  logic [15:0] last_pc;
  bit          have_last = 0;

  // memory model state
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  bit          mem_mute = 0;
  bit          stale = 0;
  bit          cur_stale = 0;

  // values seen by the DUT at the last rising edge
  logic        p_live = 1'b0;
  logic        p_stall = 1'b0;
  logic        p_redir = 1'b0;
  logic        p_rvalid = 1'b0;
  logic        p_req = 1'b0;
  logic [15:0] p_addr = '0;
  logic        p_stale = 1'b0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC35A, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},    32'(imem.imem_req), 32'd0);
    chk({tag, "_addr"},   32'(imem.imem_addr), 32'(RST_PC));
    chk({tag, "_valid"},  32'(valid_D), 32'd0);
    chk({tag, "_instr"},  instr_D, NOP_INSTR);
    chk({tag, "_pc"},     32'(pc_D), 32'd0);
    chk({tag, "_pc4"},    32'(pc_plus4_D), 32'd4);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_pfetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_pstall"}, perf_stall_cnt, 32'd0);
`endif
  endtask

  // One cycle of stimulus: memory response, random stall and redirect
  task automatic drive(input int maxlat, input int spct, input int rpct);
    logic        rv;
    logic        st_a;
    logic        st_b;
    logic        rd;
    logic [15:0] d;
    @(negedge clk);
    rv = 1'b0;
    if (imem.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(0, maxlat));
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end
      if (mem_cnt == 0 && !mem_mute) begin
        rv       = 1'b1;
        mem_busy = 1'b0;
      end
    end
    st_a = (int'($urandom_range(0, 99)) < spct);
    st_b = (int'($urandom_range(0, 99)) < spct);
    rd   = (int'($urandom_range(0, 99)) < rpct);
    d    = 16'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) d = d | 16'hFF00;
    if (rd && !(st_a | st_b)) rq.push_back('{cyc + 1, d & 16'hFFFC});
    if (st_a | st_b) exp_stall++;
    cur_stale = stale;
    stale     = (stale & !rv) | (rd & !(st_a | st_b) & imem.imem_req & !rv);
    pcw0      = st_a;
    ifidw0    = st_b;
    redirect  = rd;
    dest_pc   = d;
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rv ? mem_word(imem.imem_addr) : 32'hDEADBEEF;
  endtask

  // capture what the DUT sampled at this edge
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    p_live   <= reset;
    p_stall  <= pcw0 | ifidw0;
    p_redir  <= redirect;
    p_rvalid <= imem.imem_rvalid;
    p_req    <= imem.imem_req;
    p_addr   <= imem.imem_addr;
    p_stale  <= cur_stale;
  end

  // monitor / scoreboard
  redir_t      m_r;
  logic [15:0] m_exp;
  bit          m_got_r;
  always @(negedge clk) begin
    if (p_live && reset) begin
      if (p_redir && !p_stall) begin
        chk("flush_valid", 32'(valid_D), 32'd0);
        chk("flush_instr", instr_D, NOP_INSTR);
      end else if (p_rvalid && !p_stall && !p_stale) begin
        chk("resp_valid", 32'(valid_D), 32'd1);
        chk("resp_pc", 32'(pc_D), 32'(p_addr));
      end
      if (p_rvalid && p_stall && !p_stale) chk("hold_req", 32'(imem.imem_req), 32'd0);
      if (p_req && !p_rvalid) begin
        chk("req_held", 32'(imem.imem_req), 32'd1);
        chk("addr_stable", 32'(imem.imem_addr), 32'(p_addr));
      end
      if (!p_stall && valid_D) begin
        m_got_r = 0;
        while (rq.size() > 0 && rq[0].e < cyc) begin
          m_r = rq.pop_front();
          m_exp = m_r.tgt;
          m_got_r = 1;
        end
        if (!m_got_r) m_exp = have_last ? 16'(last_pc + 16'd4) : RST_PC;
        chk("deliver_pc", 32'(pc_D), 32'(m_exp));
        chk("deliver_instr", instr_D, mem_word(m_exp));
        chk("deliver_pc4", 32'(pc_plus4_D), 32'(16'(m_exp + 16'd4)));
        last_pc   = m_exp;
        have_last = 1;
        deliveries++;
      end
    end
  end

  logic [15:0] stale_addr;
  int          deliv_snap;
  initial begin
    reset    = 1'b0;
    pcw0     = 1'b0;
    ifidw0   = 1'b0;
    redirect = 1'b0;
    dest_pc  = '0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
    repeat (2) @(negedge clk);
    #1 check_reset("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (14)  drive(0, 0, 0);   // back-to-back responses, PC wraps past FFFC
    repeat (40)  drive(3, 0, 0);   // variable latency, no hazards
    repeat (500) drive(3, 25, 8);  // stalls and redirects mixed in
    repeat (8)   drive(2, 0, 0);
    @(negedge clk);
    #1;
    chk("progress", 32'(deliveries > 60), 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(deliveries));
    chk("perf_stall", perf_stall_cnt, 32'(exp_stall));
`endif
    // Park a request, redirect into DRAIN, then reset asynchronously mid-cycle
    mem_mute = 1;
    repeat (2) drive(0, 0, 0);
    @(negedge clk);
    chk("pre_drain_req", 32'(imem.imem_req), 32'd1);
    stale_addr = imem.imem_addr;
    pcw0 = 1'b0; ifidw0 = 1'b0;
    redirect = 1'b1; dest_pc = 16'h0042;
    imem.imem_rvalid = 1'b0;
    rq.push_back('{cyc + 1, 16'h0040});
    cur_stale = stale; stale = 1;
    @(negedge clk);
    redirect = 1'b0;
    chk("drain_req", 32'(imem.imem_req), 32'd1);
    chk("drain_addr", 32'(imem.imem_addr), 32'(stale_addr));
    #2 reset = 1'b0;
    #1 check_reset("async_drain");
    repeat (2) @(negedge clk);
    rq.delete();
    have_last = 0;
    mem_busy = 0; mem_mute = 0; stale = 0; cur_stale = 0;
    deliv_snap = deliveries;
    reset = 1'b1;
    repeat (12) drive(1, 0, 0);
    @(negedge clk);
    #1;
    chk("restart_progress", 32'(deliveries > deliv_snap + 3), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
